piso_serializer: RTL and testbench

Parallel-in/serial-out stage directly upstream of the overlapping Moore sequence detectors (e.g. cd_11011). It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on a single serial line, which feeds the detector's signal input. Back-to-back words stream with no idle gap. Framing strobes let downstream logic and benches align detector output to word boundaries.

---
 rtl/piso_serializer_pkg.sv | 19 +
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer.sv | 141 ++++++++++++++
 tb/tb_piso_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types for the parallel-in/serial-out stage: the state encoding and
// the bit-counter width helper.
package piso_serializer_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter must hold indices 0..width-1; never narrower than one bit.
   function automatic int cnt_width(input int width);
      if (width <= 2) begin
         return 1;
      end else begin
         return $clog2(width);
      end
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-side signals of the serializer, bundled so the
// source/bench and the serializer see opposite directions.
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] data_in;
   logic             serial_out;
   logic             serial_valid;
   logic             frame_first;
   logic             frame_last;
   logic             busy;

   modport master (
      output load_valid, data_in,
      input  load_ready, serial_out, serial_valid, frame_first, frame_last, busy
   );

   modport slave (
      input  load_valid, data_in,
      output load_ready, serial_out, serial_valid, frame_first, frame_last, busy
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words on a valid/ready
// handshake and streams them one bit per clock with word framing strobes.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   piso_serializer_if.slave bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
   logic [WIDTH-1:0] shift_reg_r, shift_reg_s;
   logic             serial_out_r, serial_out_s;
   logic             serial_valid_r, serial_valid_s;
   logic             frame_first_r, frame_first_s;
   logic             frame_last_r, frame_last_s;
   logic             last_s;
   logic             ready_s;
   logic             accept_s;
   logic [CW-1:0]    cnt_inc_s;

   // The bit to transmit next always sits at the outgoing end of the register.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return w[WIDTH-1];
      end else begin
         return w[0];
      end
   endfunction

   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) begin
         return {w[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, w[WIDTH-1:1]};
      end
   endfunction

   // Handshake: ready in IDLE or on the last bit of a word, never during reset.
   always_comb begin
      last_s    = (bit_cnt_r == LAST_IDX);
      cnt_inc_s = bit_cnt_r + CNT_ONE;
      if (rst) begin
         ready_s = 1'b0;
      end else if (state_r == IDLE) begin
         ready_s = 1'b1;
      end else if (state_r == SHIFT) begin
         ready_s = last_s;
      end else begin
         ready_s = 1'b0;
      end
      accept_s = bus.load_valid & ready_s;
   end

   // Next-state and next serial-side outputs.
   always_comb begin
      state_s        = state_r;
      bit_cnt_s      = bit_cnt_r;
      shift_reg_s    = shift_reg_r;
      serial_out_s   = IDLE_LEVEL;
      serial_valid_s = 1'b0;
      frame_first_s  = 1'b0;
      frame_last_s   = 1'b0;
      if (accept_s) begin
         // A fresh word wins in both IDLE and the last-bit cycle of SHIFT.
         state_s        = SHIFT;
         bit_cnt_s      = CNT_ZERO;
         shift_reg_s    = shift_once(bus.data_in);
         serial_out_s   = first_bit(bus.data_in);
         serial_valid_s = 1'b1;
         frame_first_s  = 1'b1;
         frame_last_s   = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_s     = IDLE;
               bit_cnt_s   = CNT_ZERO;
               shift_reg_s = {WIDTH{1'b0}};
            end
            SHIFT: begin
               if (last_s) begin
                  state_s     = IDLE;
                  bit_cnt_s   = CNT_ZERO;
                  shift_reg_s = {WIDTH{1'b0}};
               end else begin
                  state_s        = SHIFT;
                  bit_cnt_s      = cnt_inc_s;
                  shift_reg_s    = shift_once(shift_reg_r);
                  serial_out_s   = first_bit(shift_reg_r);
                  serial_valid_s = 1'b1;
                  frame_last_s   = (cnt_inc_s == LAST_IDX);
               end
            end
            default: begin
               state_s     = IDLE;
               bit_cnt_s   = CNT_ZERO;
               shift_reg_s = {WIDTH{1'b0}};
            end
         endcase
      end
   end

   // State and registered serial-side outputs; reset aborts any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         bit_cnt_r      <= CNT_ZERO;
         shift_reg_r    <= {WIDTH{1'b0}};
         serial_out_r   <= IDLE_LEVEL;
         serial_valid_r <= 1'b0;
         frame_first_r  <= 1'b0;
         frame_last_r   <= 1'b0;
      end else begin
         state_r        <= state_s;
         bit_cnt_r      <= bit_cnt_s;
         shift_reg_r    <= shift_reg_s;
         serial_out_r   <= serial_out_s;
         serial_valid_r <= serial_valid_s;
         frame_first_r  <= frame_first_s;
         frame_last_r   <= frame_last_s;
      end
   end

   assign bus.load_ready   = ready_s;
   assign bus.serial_out   = serial_out_r;
   assign bus.serial_valid = serial_valid_r;
   assign bus.frame_first  = frame_first_r;
   assign bus.frame_last   = frame_last_r;
   assign bus.busy         = serial_valid_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a default MSB-first instance and an LSB-first
// instance idling high, checked against a word/bit-position reference model.
module tb_piso_serializer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   piso_serializer_if #(.WIDTH(8)) ifa ();
   piso_serializer_if #(.WIDTH(8)) ifb ();

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   int         checks = 0;
   int         errors = 0;
   // Model: pos = index of the bit now on the line, -1 when idle.
   int         pos [2];
   logic [7:0] word [2];
   bit         msb [2] = '{1'b1, 1'b0};
   bit         idl [2] = '{1'b0, 1'b1};
   logic [15:0] cap_a = 16'h0000;
   logic [15:0] cap_b = 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input int d);
      if (pos[d] < 0) return idl[d];
      return msb[d] ? word[d][7 - pos[d]] : word[d][pos[d]];
   endfunction

   function automatic logic exp_ready(input int d);
      return !rst && (pos[d] < 0 || pos[d] == 7);
   endfunction

   task automatic check_dut(input int d, input logic so, input logic sv, input logic ff,
                            input logic fl, input logic bz, input logic rdy);
      chk($sformatf("dut%0d_serial_out", d),   32'(so),  32'(exp_bit(d)));
      chk($sformatf("dut%0d_serial_valid", d), 32'(sv),  32'(pos[d] >= 0));
      chk($sformatf("dut%0d_frame_first", d),  32'(ff),  32'(pos[d] == 0));
      chk($sformatf("dut%0d_frame_last", d),   32'(fl),  32'(pos[d] == 7));
      chk($sformatf("dut%0d_busy", d),         32'(bz),  32'(pos[d] >= 0));
      chk($sformatf("dut%0d_load_ready", d),   32'(rdy), 32'(exp_ready(d)));
   endtask

   task automatic check_all();
      check_dut(0, ifa.serial_out, ifa.serial_valid, ifa.frame_first, ifa.frame_last,
                ifa.busy, ifa.load_ready);
      check_dut(1, ifb.serial_out, ifb.serial_valid, ifb.frame_first, ifb.frame_last,
                ifb.busy, ifb.load_ready);
   endtask

   task automatic drv(input int d, input logic v, input logic [7:0] x);
      if (d == 0) begin
         ifa.load_valid = v;
         ifa.data_in    = x;
      end else begin
         ifb.load_valid = v;
         ifb.data_in    = x;
      end
   endtask

   // One clock: decide accepts from the model, take the edge, advance, check.
   task automatic cycle();
      logic       acc [2];
      logic [7:0] dat [2];
      acc[0] = ifa.load_valid && exp_ready(0);
      acc[1] = ifb.load_valid && exp_ready(1);
      dat[0] = ifa.data_in;
      dat[1] = ifb.data_in;
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            pos[d] = -1;
         end else if (acc[d]) begin
            pos[d]  = 0;
            word[d] = dat[d];
         end else if (pos[d] == 7) begin
            pos[d] = -1;
         end else if (pos[d] >= 0) begin
            pos[d] = pos[d] + 1;
         end
      end
      cap_a = {cap_a[14:0], ifa.serial_out};
      cap_b = {cap_b[14:0], ifb.serial_out};
      check_all();
   endtask

   initial begin
      pos[0] = -1;
      pos[1] = -1;
      word[0] = 8'h00;
      word[1] = 8'h00;
      rst = 1'b1;
      drv(0, 1'b0, 8'h00);
      drv(1, 1'b0, 8'h00);
      #12;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();
      repeat (3) cycle();

      // Single word, MSB first.
      drv(0, 1'b1, 8'b11011011);
      cycle();
      drv(0, 1'b0, 8'h00);
      repeat (7) cycle();
      chk("single_word_bits", 32'(cap_a[7:0]), 32'h000000DB);
      cycle();
      chk("single_word_idle_valid", 32'(ifa.serial_valid), 32'h0);

      // Back-to-back words with the second presented in the last-bit cycle.
      drv(0, 1'b1, 8'hA5);
      cycle();
      drv(0, 1'b0, 8'h00);
      repeat (7) cycle();
      drv(0, 1'b1, 8'h3C);
      cycle();
      drv(0, 1'b0, 8'h00);
      repeat (7) cycle();
      chk("back_to_back_bits", 32'(cap_a), 32'(16'b1010010100111100));
      cycle();

      // LSB-first instance.
      drv(1, 1'b1, 8'h01);
      cycle();
      drv(1, 1'b0, 8'h00);
      repeat (7) cycle();
      chk("lsb_first_bits", 32'(cap_b[7:0]), 32'h00000080);
      repeat (2) cycle();

      // Stall: valid held high with changing data while a word is in flight.
      drv(0, 1'b1, 8'h96);
      cycle();
      repeat (7) begin
         drv(0, 1'b1, 8'($urandom));
         cycle();
      end
      drv(0, 1'b1, 8'h5A);
      cycle();
      drv(0, 1'b0, 8'h00);
      repeat (7) cycle();
      chk("stall_words", 32'(cap_a), 32'h0000965A);
      cycle();

      // Asynchronous reset during bit 3.
      drv(0, 1'b1, 8'hC3);
      cycle();
      drv(0, 1'b0, 8'h00);
      repeat (3) cycle();
      #2;
      rst = 1'b1;
      #1;
      pos[0] = -1;
      pos[1] = -1;
      check_all();
      chk("reset_abort_valid", 32'(ifa.serial_valid), 32'h0);
      chk("reset_abort_last", 32'(ifa.frame_last), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();
      drv(0, 1'b1, 8'hFF);
      cycle();
      drv(0, 1'b0, 8'h00);
      repeat (7) cycle();
      chk("after_reset_word", 32'(cap_a[7:0]), 32'h000000FF);
      cycle();

      // Randomized traffic on both instances.
      repeat (400) begin
         drv(0, ($urandom_range(0, 3) != 0), 8'($urandom));
         drv(1, ($urandom_range(0, 2) == 0), 8'($urandom));
         cycle();
      end
      drv(0, 1'b0, 8'h00);
      drv(1, 1'b0, 8'h00);
      repeat (10) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
